surf_word_capture: RTL and testbench
====================================

# surf_word_capture

Parametrised successor to the fixed COUT/DOUT byte capture in the SURF input path. It takes the per-`sysclk` slice from the SURF ISERDES (`LANE_BITS` bits per clock) and assembles `WORD_BITS`-wide words framed by `sync_i`. It provides a streaming output, a one-shot capture register, training-pattern checking with lock detection, and a saturating bit-error counter. It sits between `surf_cout_phy_v2` and the TURFIO register/command logic, one instance per SURF link (COUT at 4→32, DOUT at 8→8 or 8→32).

## Interface
Parameters:
- `LANE_BITS`, 4: bits delivered per `sysclk` by the ISERDES.
- `WORD_BITS`, 32: assembled word width. Must be an integer multiple of `LANE_BITS`. `NBEATS = WORD_BITS/LANE_BITS` is in the range 1..16; other values are an elaboration error.
- `TRAIN_PATTERN`, 32'hA55A_6996: expected word in training mode. The low `WORD_BITS` bits are used.
- `LOCK_COUNT`, 8: consecutive matching training words required to assert lock. Range 1..255.
- `ERR_BITS`, 16: width of the error counter.

Ports:
- `sysclk_i` in 1: the only clock.
- `sysclk_rstn_i` in 1: reset, synchronous, active-low.
- `sync_i` in 1: one-cycle frame marker. It coincides with the last beat of a word.
- `lane_i` in `LANE_BITS`: ISERDES slice. Index `LANE_BITS-1` is the earliest bit.
- `enable_i` in 1: gates the stream output.
- `train_i` in 1: 1 selects training checking; 0 selects data.
- `capture_i` in 1: arms a one-shot capture.
- `err_clear_i` in 1: clears `err_count_o` and `misalign_o`.
- `stream_data_o` out `WORD_BITS`: last completed word.
- `stream_valid_o` out 1: one-cycle strobe per completed word.
- `capture_data_o` out `WORD_BITS`: captured word.
- `capture_valid_o` out 1: level signal; high while `capture_data_o` holds an unconsumed capture.
- `aligned_o` out 1: set when the first `sync_i` is seen after reset.
- `misalign_o` out 1: sticky flag; `sync_i` arrived on the wrong beat.
- `locked_o` out 1: training lock indicator.
- `biterr_o` out 1: one-cycle strobe when a training word mismatches.
- `err_count_o` out `ERR_BITS`: saturating count of mismatched training words.

## Operation
- **Beat counter `b`** (0..`NBEATS-1`):
  - Increments every cycle and wraps to 0 after `NBEATS-1`.
  - `sync_i` forces the next value of `b` to 0.
  - If `b != NBEATS-1` when `sync_i` is high, set `misalign_o`. The partial word is discarded and no strobe is emitted.
- **Shift register:** `sr <= {sr[WORD_BITS-LANE_BITS-1:0], lane_i}`. The first beat lands in the MSBs. When `NBEATS==1`, `sr <= lane_i`.
- **Word completion:** a word completes in any cycle where `b==NBEATS-1`, `aligned_o==1`, and `sync_i` is not mid-word. On completion:
  - `stream_data_o` loads the word unconditionally.
  - `stream_valid_o` pulses only if `enable_i` is high.
- **Before first sync:** after reset, `b` free-runs from 0 and no word completes until `aligned_o==1`.
- **Capture:**
  - `capture_i` high sets `armed` and clears `capture_valid_o` in the same edge.
  - The next completed word loads `capture_data_o`, sets `capture_valid_o`, and clears `armed`.
  - If `capture_i` is high on a completion cycle, the current word is captured. `capture_valid_o` goes high next cycle and `armed` ends up 0.
- **Training** (`train_i==1`), evaluated per completed word:
  - **Match:** `match_cnt` increments, saturating at `LOCK_COUNT`. `locked_o` sets when the count reaches `LOCK_COUNT`.
  - **Mismatch:**
    - `match_cnt` and `locked_o` are cleared.
    - `biterr_o` pulses.
    - `err_count_o` increments, saturating at all-ones.
  - `train_i==0`: `match_cnt`, `locked_o` and `biterr_o` are held at 0. `err_count_o` is held at its value.
- **Error clear:** `err_clear_i` clears `err_count_o` and `misalign_o`. If it coincides with an increment or a set, the clear wins.
- **Reset values:** every output is 0, and `b`, `sr`, `armed` and `match_cnt` are 0.

## Timing
- Latency from the last beat's `lane_i` sample to `stream_data_o`, `stream_valid_o`, `biterr_o` and `capture_valid_o`: 1 cycle. All of these are registered.
- `locked_o` and `err_count_o` update on the same edge as `biterr_o`.
- `sync_i` sampled in cycle N: the `lane_i` sampled in cycle N+1 is beat 0. `aligned_o` rises at N+1.
- Word rate is one per `NBEATS` cycles. Back-to-back `stream_valid_o` pulses are possible only when `NBEATS==1`.
- Reset asserted mid-word aborts the word with no strobe. The first post-reset strobe requires a new `sync_i`.

## Structure
- **Package `surf_cout_pkg`:**
  - default `TRAIN_PATTERN` constants for COUT (32'hA55A_6996) and DOUT (8'h6A);
  - `typedef enum {MODE_DATA, MODE_TRAIN}`;
  - the `NBEATS` legality function.
- **Sub-module `surf_word_checker`:** pattern compare, `match_cnt`, `locked_o`, `biterr_o` and the saturating `err_count_o`. It is fed by word, word-valid and `train_i`.
- The top-level block holds the beat counter, shift register, stream path and capture path.

## Test plan
- **COUT defaults (4/32):** after reset, no strobes before the first sync. Assert `sync_i` on `b==7`, then drive nibbles 1..8 → `stream_data_o==32'h12345678` one cycle after the 8th nibble, with a one-cycle `stream_valid_o`. Repeating continues every 8 cycles.
- **Training:** `train_i=1`, feed 8 words of 32'hA55A6996 → `locked_o` rises with the 8th strobe. Corrupt 1 bit of the 9th word → `biterr_o` pulses, `locked_o` drops, `err_count_o==1`.
- **Sync mid-word:** `sync_i` at `b==3` → `misalign_o` set, that word produces no strobe, and the next word is aligned to the new frame. `err_clear_i` then clears `misalign_o`.
- **Capture:** `capture_i` during beat 2 of word W → `capture_data_o==W`, `capture_valid_o` high until the next `capture_i`. `capture_i` on a completion cycle → the current word is captured.
- **Error saturation and reset:** with `ERR_BITS=4`, 20 mismatches → `err_count_o` holds at 4'hF. Then `err_clear_i` together with a mismatch → 0.
- **DOUT (8/8, `NBEATS=1`), enable and reset:** `stream_valid_o` is high every cycle with `stream_data_o` equal to `lane_i` delayed 1 cycle. `enable_i=0` suppresses `stream_valid_o` only. Reset mid-stream zeroes all outputs.

Source files
------------

// File: rtl/surf_cout_pkg.sv
// Shared constants, mode type and parameter legality helper for the SURF
// COUT/DOUT word capture path.
package surf_cout_pkg;

  localparam logic [31:0] COUT_TRAIN_PATTERN = 32'hA55A_6996;
  localparam logic [7:0]  DOUT_TRAIN_PATTERN = 8'h6A;

  typedef enum logic {
    MODE_DATA  = 1'b0,
    MODE_TRAIN = 1'b1
  } surf_mode_e;

  // A word must be a whole number of lane slices, 1..16 beats long.
  function automatic bit nbeats_legal(input int unsigned lane_bits,
                                      input int unsigned word_bits);
    if (lane_bits == 0) return 1'b0;
    if ((word_bits % lane_bits) != 0) return 1'b0;
    return ((word_bits / lane_bits) >= 1) && ((word_bits / lane_bits) <= 16);
  endfunction

endpackage

// File: rtl/surf_word_checker.sv
// Training-pattern checker: match counting, lock detection, mismatch strobe
// and a saturating mismatch counter.
module surf_word_checker
  import surf_cout_pkg::*;
#(
  parameter int unsigned WORD_BITS     = 32,
  parameter logic [31:0] TRAIN_PATTERN = COUT_TRAIN_PATTERN,
  parameter int unsigned LOCK_COUNT    = 8,
  parameter int unsigned ERR_BITS      = 16
) (
  input  logic                 sysclk_i,
  input  logic                 sysclk_rstn_i,
  input  logic [WORD_BITS-1:0] word_i,
  input  logic                 word_valid_i,
  input  logic                 train_i,
  input  logic                 err_clear_i,
  output logic                 locked_o,
  output logic                 biterr_o,
  output logic [ERR_BITS-1:0]  err_count_o
);

  localparam logic [WORD_BITS-1:0] PATTERN  = WORD_BITS'(TRAIN_PATTERN);
  localparam logic [7:0]           LOCK_MAX = 8'(LOCK_COUNT);

  surf_mode_e          mode;
  logic [7:0]          match_cnt_q, match_cnt_d;
  logic                locked_q, locked_d;
  logic                biterr_q, biterr_d;
  logic [ERR_BITS-1:0] err_count_q, err_count_d;

  assign mode = train_i ? MODE_TRAIN : MODE_DATA;

  always_comb begin
    match_cnt_d = match_cnt_q;
    locked_d    = locked_q;
    biterr_d    = 1'b0;
    err_count_d = err_count_q;
    if (mode == MODE_DATA) begin
      match_cnt_d = '0;
      locked_d    = 1'b0;
    end else if (word_valid_i) begin
      if (word_i == PATTERN) begin
        if (match_cnt_q != LOCK_MAX) match_cnt_d = match_cnt_q + 8'd1;
        if (match_cnt_d == LOCK_MAX) locked_d = 1'b1;
      end else begin
        match_cnt_d = '0;
        locked_d    = 1'b0;
        biterr_d    = 1'b1;
        if (err_count_q != '1) err_count_d = err_count_q + ERR_BITS'(1);
      end
    end
    // Clear has priority over a same-cycle increment.
    if (err_clear_i) err_count_d = '0;
  end

  always_ff @(posedge sysclk_i) begin
    if (!sysclk_rstn_i) begin
      match_cnt_q <= '0;
      locked_q    <= 1'b0;
      biterr_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      match_cnt_q <= match_cnt_d;
      locked_q    <= locked_d;
      biterr_q    <= biterr_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked_o    = locked_q;
  assign biterr_o    = biterr_q;
  assign err_count_o = err_count_q;

endmodule

// File: rtl/surf_word_capture.sv
// Assembles sync-framed words from ISERDES lane slices; provides a stream
// output, a one-shot capture register and training-pattern checking.
module surf_word_capture
  import surf_cout_pkg::*;
#(
  parameter int unsigned LANE_BITS     = 4,
  parameter int unsigned WORD_BITS     = 32,
  parameter logic [31:0] TRAIN_PATTERN = COUT_TRAIN_PATTERN,
  parameter int unsigned LOCK_COUNT    = 8,
  parameter int unsigned ERR_BITS      = 16
) (
  input  logic                 sysclk_i,
  input  logic                 sysclk_rstn_i,
  input  logic                 sync_i,
  input  logic [LANE_BITS-1:0] lane_i,
  input  logic                 enable_i,
  input  logic                 train_i,
  input  logic                 capture_i,
  input  logic                 err_clear_i,
  output logic [WORD_BITS-1:0] stream_data_o,
  output logic                 stream_valid_o,
  output logic [WORD_BITS-1:0] capture_data_o,
  output logic                 capture_valid_o,
  output logic                 aligned_o,
  output logic                 misalign_o,
  output logic                 locked_o,
  output logic                 biterr_o,
  output logic [ERR_BITS-1:0]  err_count_o
);

  localparam int unsigned NBEATS    = WORD_BITS / LANE_BITS;
  localparam logic [3:0]  LAST_BEAT = 4'(NBEATS - 1);

  if (!nbeats_legal(LANE_BITS, WORD_BITS) || LOCK_COUNT < 1 || LOCK_COUNT > 255)
  begin : g_bad_params
    $error("surf_word_capture: illegal LANE_BITS/WORD_BITS/LOCK_COUNT");
  end

  logic [3:0]           b_q, b_d;
  logic                 aligned_q, aligned_d;
  logic                 misalign_q, misalign_d;
  logic [WORD_BITS-1:0] stream_data_q, stream_data_d;
  logic                 stream_valid_q, stream_valid_d;
  logic [WORD_BITS-1:0] capture_data_q, capture_data_d;
  logic                 capture_valid_q, capture_valid_d;
  logic                 armed_q, armed_d;
  logic [WORD_BITS-1:0] word;
  logic                 complete;

  // Only the bits that survive into the next word are kept; the word
  // presented on the last beat includes the live lane slice.
  if (NBEATS == 1) begin : g_single
    assign word = lane_i;
  end else begin : g_multi
    logic [WORD_BITS-LANE_BITS-1:0] sr_q;
    always_ff @(posedge sysclk_i) begin
      if (!sysclk_rstn_i) sr_q <= '0;
      else                sr_q <= word[WORD_BITS-LANE_BITS-1:0];
    end
    assign word = {sr_q, lane_i};
  end

  always_comb begin
    complete   = (b_q == LAST_BEAT) && aligned_q;
    b_d        = (sync_i || (b_q == LAST_BEAT)) ? '0 : b_q + 4'd1;
    aligned_d  = aligned_q | sync_i;
    misalign_d = misalign_q | (sync_i && (b_q != LAST_BEAT));
    if (err_clear_i) misalign_d = 1'b0;

    stream_data_d  = complete ? word : stream_data_q;
    stream_valid_d = complete && enable_i;

    armed_d         = armed_q;
    capture_valid_d = capture_valid_q;
    capture_data_d  = capture_data_q;
    if (capture_i) begin
      armed_d         = 1'b1;
      capture_valid_d = 1'b0;
    end
    // A capture request on the completion cycle takes the current word.
    if (complete && (armed_q || capture_i)) begin
      armed_d         = 1'b0;
      capture_valid_d = 1'b1;
      capture_data_d  = word;
    end
  end

  always_ff @(posedge sysclk_i) begin
    if (!sysclk_rstn_i) begin
      b_q             <= '0;
      aligned_q       <= 1'b0;
      misalign_q      <= 1'b0;
      stream_data_q   <= '0;
      stream_valid_q  <= 1'b0;
      capture_data_q  <= '0;
      capture_valid_q <= 1'b0;
      armed_q         <= 1'b0;
    end else begin
      b_q             <= b_d;
      aligned_q       <= aligned_d;
      misalign_q      <= misalign_d;
      stream_data_q   <= stream_data_d;
      stream_valid_q  <= stream_valid_d;
      capture_data_q  <= capture_data_d;
      capture_valid_q <= capture_valid_d;
      armed_q         <= armed_d;
    end
  end

  surf_word_checker #(
    .WORD_BITS    (WORD_BITS),
    .TRAIN_PATTERN(TRAIN_PATTERN),
    .LOCK_COUNT   (LOCK_COUNT),
    .ERR_BITS     (ERR_BITS)
  ) u_checker (
    .sysclk_i     (sysclk_i),
    .sysclk_rstn_i(sysclk_rstn_i),
    .word_i       (word),
    .word_valid_i (complete),
    .train_i      (train_i),
    .err_clear_i  (err_clear_i),
    .locked_o     (locked_o),
    .biterr_o     (biterr_o),
    .err_count_o  (err_count_o)
  );

  assign stream_data_o   = stream_data_q;
  assign stream_valid_o  = stream_valid_q;
  assign capture_data_o  = capture_data_q;
  assign capture_valid_o = capture_valid_q;
  assign aligned_o       = aligned_q;
  assign misalign_o      = misalign_q;

endmodule

// File: tb/tb_surf_word_capture.sv
// Directed bench for surf_word_capture: a 4->32 COUT instance (ERR_BITS=4)
// and an 8->8 DOUT instance sharing one clock.
module tb_surf_word_capture;
  import surf_cout_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // COUT instance signals
  logic        a_rstn, a_sync, a_enable, a_train, a_capture, a_err_clear;
  logic [3:0]  a_lane;
  logic [31:0] a_stream_data, a_capture_data;
  logic        a_stream_valid, a_capture_valid, a_aligned, a_misalign;
  logic        a_locked, a_biterr;
  logic [3:0]  a_err_count;

  // DOUT instance signals
  logic        b_rstn, b_sync, b_enable, b_train, b_capture, b_err_clear;
  logic [7:0]  b_lane;
  logic [7:0]  b_stream_data, b_capture_data;
  logic        b_stream_valid, b_capture_valid, b_aligned, b_misalign;
  logic        b_locked, b_biterr;
  logic [15:0] b_err_count;

  surf_word_capture #(
    .LANE_BITS(4), .WORD_BITS(32), .TRAIN_PATTERN(COUT_TRAIN_PATTERN),
    .LOCK_COUNT(8), .ERR_BITS(4)
  ) u_cout (
    .sysclk_i(clk), .sysclk_rstn_i(a_rstn), .sync_i(a_sync), .lane_i(a_lane),
    .enable_i(a_enable), .train_i(a_train), .capture_i(a_capture),
    .err_clear_i(a_err_clear), .stream_data_o(a_stream_data),
    .stream_valid_o(a_stream_valid), .capture_data_o(a_capture_data),
    .capture_valid_o(a_capture_valid), .aligned_o(a_aligned),
    .misalign_o(a_misalign), .locked_o(a_locked), .biterr_o(a_biterr),
    .err_count_o(a_err_count)
  );

  surf_word_capture #(
    .LANE_BITS(8), .WORD_BITS(8), .TRAIN_PATTERN({24'h0, DOUT_TRAIN_PATTERN}),
    .LOCK_COUNT(8), .ERR_BITS(16)
  ) u_dout (
    .sysclk_i(clk), .sysclk_rstn_i(b_rstn), .sync_i(b_sync), .lane_i(b_lane),
    .enable_i(b_enable), .train_i(b_train), .capture_i(b_capture),
    .err_clear_i(b_err_clear), .stream_data_o(b_stream_data),
    .stream_valid_o(b_stream_valid), .capture_data_o(b_capture_data),
    .capture_valid_o(b_capture_valid), .aligned_o(b_aligned),
    .misalign_o(b_misalign), .locked_o(b_locked), .biterr_o(b_biterr),
    .err_count_o(b_err_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One 8-beat COUT word, sync on the last beat; optional capture pulse on
  // beat cap_beat (-1 for none) and err_clear on the last beat.
  task automatic a_word(input logic [31:0] w, input int cap_beat, input bit clr_last);
    for (int i = 0; i < 8; i++) begin
      a_lane      = w[31-4*i -: 4];
      a_sync      = (i == 7);
      a_capture   = (i == cap_beat);
      a_err_clear = clr_last && (i == 7);
      step();
      if (i == 0) begin
        chk("valid_gap", a_stream_valid, 1'b0);
        chk("biterr_gap", a_biterr, 1'b0);
      end
      if (cap_beat >= 0 && cap_beat < 7 && i == cap_beat)
        chk("cap_arm_clears_valid", a_capture_valid, 1'b0);
    end
    a_sync = 1'b0; a_capture = 1'b0; a_err_clear = 1'b0;
  endtask

  task automatic a_zero_outputs(input string tag);
    chk({tag, "_data"}, a_stream_data, 32'h0);
    chk({tag, "_valid"}, a_stream_valid, 1'b0);
    chk({tag, "_capdata"}, a_capture_data, 32'h0);
    chk({tag, "_capvalid"}, a_capture_valid, 1'b0);
    chk({tag, "_aligned"}, a_aligned, 1'b0);
    chk({tag, "_misalign"}, a_misalign, 1'b0);
    chk({tag, "_locked"}, a_locked, 1'b0);
    chk({tag, "_biterr"}, a_biterr, 1'b0);
    chk({tag, "_errcnt"}, a_err_count, 4'h0);
  endtask

  logic [7:0] dout_vec [6] = '{8'h6A, 8'h01, 8'hFF, 8'h80, 8'h3C, 8'hA5};

  initial begin
    a_rstn = 1'b0; a_sync = 1'b0; a_lane = '0; a_enable = 1'b1; a_train = 1'b0;
    a_capture = 1'b0; a_err_clear = 1'b0;
    b_rstn = 1'b0; b_sync = 1'b0; b_lane = '0; b_enable = 1'b1; b_train = 1'b0;
    b_capture = 1'b0; b_err_clear = 1'b0;

    // ---- COUT reset and first sync ----
    repeat (3) step();
    a_zero_outputs("rst");
    a_rstn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a_lane = 4'hF;
      step();
      chk("pre_sync_valid", a_stream_valid, 1'b0);
      chk("pre_sync_aligned", a_aligned, 1'b0);
    end
    a_sync = 1'b1;
    step();
    a_sync = 1'b0;
    chk("sync_aligned", a_aligned, 1'b1);
    chk("sync_misalign", a_misalign, 1'b0);
    chk("sync_no_valid", a_stream_valid, 1'b0);

    // ---- streaming ----
    a_word(32'h12345678, -1, 1'b0);
    chk("w1_data", a_stream_data, 32'h12345678);
    chk("w1_valid", a_stream_valid, 1'b1);
    a_word(32'hCAFEF00D, -1, 1'b0);
    chk("w2_data", a_stream_data, 32'hCAFEF00D);
    chk("w2_valid", a_stream_valid, 1'b1);
    a_enable = 1'b0;
    a_word(32'h0BADBEEF, -1, 1'b0);
    chk("en0_data", a_stream_data, 32'h0BADBEEF);
    chk("en0_valid", a_stream_valid, 1'b0);
    a_enable = 1'b1;

    // ---- training and lock ----
    a_train = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a_word(32'hA55A6996, -1, 1'b0);
      chk("train_locked", a_locked, (k == 7));
      chk("train_biterr", a_biterr, 1'b0);
    end
    a_word(32'hA55A6997, -1, 1'b0);
    chk("bad_biterr", a_biterr, 1'b1);
    chk("bad_locked", a_locked, 1'b0);
    chk("bad_errcnt", a_err_count, 4'h1);

    // ---- error saturation, hold in data mode, clear priority ----
    for (int k = 0; k < 20; k++) a_word(32'h00000000, -1, 1'b0);
    chk("sat_errcnt", a_err_count, 4'hF);
    chk("sat_biterr", a_biterr, 1'b1);
    a_train = 1'b0;
    a_word(32'h00000000, -1, 1'b0);
    chk("data_hold_errcnt", a_err_count, 4'hF);
    chk("data_biterr", a_biterr, 1'b0);
    a_train = 1'b1;
    a_word(32'h00000000, -1, 1'b1);
    chk("clr_wins_errcnt", a_err_count, 4'h0);
    chk("clr_biterr", a_biterr, 1'b1);
    a_train = 1'b0;

    // ---- capture ----
    a_word(32'h11112222, 2, 1'b0);
    chk("cap1_valid", a_capture_valid, 1'b1);
    chk("cap1_data", a_capture_data, 32'h11112222);
    a_word(32'h33334444, -1, 1'b0);
    chk("cap1_hold_valid", a_capture_valid, 1'b1);
    chk("cap1_hold_data", a_capture_data, 32'h11112222);
    a_word(32'h55556666, 7, 1'b0);
    chk("cap_last_valid", a_capture_valid, 1'b1);
    chk("cap_last_data", a_capture_data, 32'h55556666);
    a_word(32'h77778888, -1, 1'b0);
    chk("cap_disarmed_data", a_capture_data, 32'h55556666);
    a_word(32'h9999AAAA, 2, 1'b0);
    chk("cap2_data", a_capture_data, 32'h9999AAAA);
    chk("cap2_valid", a_capture_valid, 1'b1);

    // ---- sync mid-word ----
    for (int i = 0; i < 4; i++) begin
      a_lane = 4'h5;
      a_sync = (i == 3);
      step();
      chk("mid_no_valid", a_stream_valid, 1'b0);
    end
    a_sync = 1'b0;
    chk("mid_misalign", a_misalign, 1'b1);
    a_word(32'hDEADBEEF, -1, 1'b0);
    chk("realign_data", a_stream_data, 32'hDEADBEEF);
    chk("realign_valid", a_stream_valid, 1'b1);
    chk("misalign_sticky", a_misalign, 1'b1);
    a_word(32'h01020304, -1, 1'b1);
    chk("misalign_cleared", a_misalign, 1'b0);
    chk("clr_word_data", a_stream_data, 32'h01020304);

    // ---- reset mid-word ----
    for (int i = 0; i < 3; i++) begin
      a_lane = 4'hA;
      step();
    end
    a_rstn = 1'b0;
    repeat (2) step();
    a_zero_outputs("midrst");
    a_rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_lane = 4'(i);
      step();
      chk("post_rst_no_valid", a_stream_valid, 1'b0);
    end
    chk("post_rst_aligned", a_aligned, 1'b0);

    // ---- DOUT 8->8 ----
    b_rstn = 1'b1;
    b_lane = 8'h77;
    step();
    chk("dout_pre_valid", b_stream_valid, 1'b0);
    b_sync = 1'b1;
    b_lane = 8'h42;
    step();
    b_sync = 1'b0;
    chk("dout_aligned", b_aligned, 1'b1);
    chk("dout_sync_valid", b_stream_valid, 1'b0);
    for (int i = 0; i < 6; i++) begin
      b_lane = dout_vec[i];
      step();
      chk("dout_data", b_stream_data, dout_vec[i]);
      chk("dout_valid", b_stream_valid, 1'b1);
    end
    chk("dout_misalign", b_misalign, 1'b0);
    b_enable = 1'b0;
    b_lane = 8'h5C;
    step();
    chk("dout_en0_data", b_stream_data, 8'h5C);
    chk("dout_en0_valid", b_stream_valid, 1'b0);
    b_enable = 1'b1;
    b_lane = 8'h3E;
    step();
    chk("dout_en1_data", b_stream_data, 8'h3E);
    chk("dout_en1_valid", b_stream_valid, 1'b1);
    b_rstn = 1'b0;
    step();
    chk("dout_rst_data", b_stream_data, 8'h00);
    chk("dout_rst_valid", b_stream_valid, 1'b0);
    chk("dout_rst_aligned", b_aligned, 1'b0);
    chk("dout_rst_capvalid", b_capture_valid, 1'b0);
    chk("dout_rst_errcnt", b_err_count, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
